// File: rtl/bcd_conv_ctrl.sv
// Serial double-dabble binary-to-BCD converter with start/done handshake,
// sign extraction and leading-digit index for the seven-segment display path.
module bcd_conv_ctrl #(
  parameter int W      = 16,
  parameter int DIGITS = 5,
  parameter int IW     = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                signed_mode,
  input  logic [W-1:0]        bin_in,
  output logic                busy,
  output logic                done,
  output logic                sign,
  output logic [4*DIGITS-1:0] bcd,
  output logic [IW-1:0]       ms_digit
);
  // state   | meaning
  // S_IDLE  | waiting for start; captures bin_in and sign flag
  // S_LOAD  | forms magnitude, clears scratch and bit counter
  // S_SHIFT | W cycles of add-3 then shift-left
  // S_DONE  | results visible, done pulse

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [W-1:0]    r_bin, r_mag, w_mag_next;
  logic            r_neg, r_sign;
  logic [BW-1:0]   r_scr, r_bcd, w_adj, w_scr_next;
  logic [BW+W-1:0] w_cat;
  logic [CW-1:0]   r_cnt;
  logic [IW-1:0]   r_ms, w_ms;
  logic            w_last;

  assign w_last = (r_cnt == CW'(W - 1));

  always_comb begin
    w_adj = r_scr;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_scr[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_scr[4*d +: 4] + 4'd3;
    end
    w_cat      = {w_adj, r_mag} << 1;
    w_scr_next = w_cat[BW+W-1:W];
    w_mag_next = w_cat[W-1:0];
  end

  // Leading digit is taken from the final shifted scratch so it lands with bcd.
  always_comb begin
    w_ms = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_scr_next[4*d +: 4] != 4'd0) w_ms = IW'(d);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD:  w_next = S_SHIFT;
      S_SHIFT: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_neg  <= 1'b0;
      r_mag  <= '0;
      r_scr  <= '0;
      r_cnt  <= '0;
      r_bcd  <= '0;
      r_sign <= 1'b0;
      r_ms   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_bin <= bin_in;
          r_neg <= signed_mode & bin_in[W-1];
        end
        S_LOAD: begin
          r_mag <= r_neg ? (~r_bin + W'(1)) : r_bin;
          r_scr <= '0;
          r_cnt <= '0;
        end
        S_SHIFT: begin
          r_scr <= w_scr_next;
          r_mag <= w_mag_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_bcd  <= w_scr_next;
            r_sign <= r_neg;
            r_ms   <= w_ms;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign sign     = r_sign;
  assign bcd      = r_bcd;
  assign ms_digit = r_ms;

endmodule
